// File: rtl/tile_fifo_ctl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tile_fifo_ctl_if : push/pop handshake, tile data and status bundle  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface tile_fifo_ctl_if #(
    parameter int BITS  = 8,
    parameter int SIZE  = 2,
    parameter int DEPTH = 3
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic                                 flush;
    logic                                 push;
    logic                                 push_rdy;
    logic [SIZE-1:0][SIZE-1:0][BITS-1:0]  din;
`ifdef TILE_FIFO_TRANSPOSE_EN
    logic                                 din_transpose;
`endif
    logic                                 pop;
    logic                                 pop_rdy;
    logic [SIZE-1:0][SIZE-1:0][BITS-1:0]  dout;
    logic [c_cnt_w-1:0]                   count;
    logic                                 full;
    logic                                 empty;
    logic                                 almost_full;
    logic                                 almost_empty;

    modport master (
        output flush, push, din, pop,
`ifdef TILE_FIFO_TRANSPOSE_EN
        output din_transpose,
`endif
        input  push_rdy, pop_rdy, dout, count, full, empty, almost_full, almost_empty
    );

    modport slave (
        input  flush, push, din, pop,
`ifdef TILE_FIFO_TRANSPOSE_EN
        input  din_transpose,
`endif
        output push_rdy, pop_rdy, dout, count, full, empty, almost_full, almost_empty
    );
endinterface
`default_nettype wire

// File: rtl/tile_fifo_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tile_fifo_ctl : DEPTH-entry first-word-fall-through tile FIFO with  |
// | flush and almost flags; TILE_FIFO_TRANSPOSE_EN adds write transpose |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tile_fifo_ctl #(
    parameter int BITS         = 8,
    parameter int SIZE         = 2,
    parameter int DEPTH        = 3,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    tile_fifo_ctl_if.slave    bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_afull     = c_cnt_w'(AFULL_LEVEL);
    localparam logic [c_cnt_w-1:0] c_aempty    = c_cnt_w'(AEMPTY_LEVEL);

    typedef logic [SIZE-1:0][SIZE-1:0][BITS-1:0] tile_t;

    tile_t              mem_q [DEPTH];
    logic [c_ptr_w-1:0] head_q, head_d;
    logic [c_ptr_w-1:0] tail_q, tail_d;
    logic [c_cnt_w-1:0] count_q, count_d;

    logic  w_full;
    logic  w_empty;
    logic  w_push_acc;
    logic  w_pop_acc;
    logic  w_wr_en;
    tile_t w_wr_tile;

    // Explicit wrap keeps pointers inside 0..DEPTH-1 for non-power-of-two depths
    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign w_full     = (count_q == c_depth_cnt);
    assign w_empty    = (count_q == '0);
    assign w_push_acc = bus.push && !w_full;
    assign w_pop_acc  = bus.pop && !w_empty;
    assign w_wr_en    = rst_n && !bus.flush && w_push_acc;

`ifdef TILE_FIFO_TRANSPOSE_EN
    tile_t w_din_tr;
    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            assign w_din_tr[i][j] = bus.din[j][i];
        end
    end
    assign w_wr_tile = bus.din_transpose ? w_din_tr : bus.din;
`else
    assign w_wr_tile = bus.din;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push_acc) tail_d = next_ptr(tail_q);
            if (w_pop_acc)  head_d = next_ptr(head_q);
            case ({w_push_acc, w_pop_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left unreset; dout masking hides stale entries
    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[tail_q] <= w_wr_tile;
    end

    assign bus.push_rdy     = !w_full;
    assign bus.pop_rdy      = !w_empty;
    assign bus.dout         = w_empty ? '0 : mem_q[head_q];
    assign bus.count        = count_q;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (count_q >= c_afull);
    assign bus.almost_empty = (count_q <= c_aempty);

`ifndef SYNTHESIS
    a_count_le_depth: assert property (@(posedge clk) count_q <= c_depth_cnt);
    a_head_in_range:  assert property (@(posedge clk) head_q <= c_last_ptr);
    a_tail_in_range:  assert property (@(posedge clk) tail_q <= c_last_ptr);
`endif
endmodule
`default_nettype wire

// File: tb/tb_tile_fifo_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tile_fifo_ctl : directed bench for tile_fifo_ctl (DEPTH 5 and 3) |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_tile_fifo_ctl;
    typedef logic [1:0][1:0][7:0] tile_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    tile_fifo_ctl_if #(.BITS(8), .SIZE(2), .DEPTH(5)) if5 ();
    tile_fifo_ctl_if #(.BITS(8), .SIZE(2), .DEPTH(3)) if3 ();

    tile_fifo_ctl #(.BITS(8), .SIZE(2), .DEPTH(5), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if5.slave)
    );

    tile_fifo_ctl #(.BITS(8), .SIZE(2), .DEPTH(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic tile_t fill(input logic [7:0] v);
        return {4{v}};
    endfunction

    task automatic flags5(input string tag, input int c);
        check({tag, ".count"},    32'(if5.count),        32'(c));
        check({tag, ".empty"},    32'(if5.empty),        32'(c == 0));
        check({tag, ".full"},     32'(if5.full),         32'(c == 5));
        check({tag, ".push_rdy"}, 32'(if5.push_rdy),     32'(c != 5));
        check({tag, ".pop_rdy"},  32'(if5.pop_rdy),      32'(c != 0));
        check({tag, ".afull"},    32'(if5.almost_full),  32'(c >= 4));
        check({tag, ".aempty"},   32'(if5.almost_empty), 32'(c <= 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if5.flush = 1'b0; if5.push = 1'b0; if5.pop = 1'b0; if5.din = '0;
        if3.flush = 1'b0; if3.push = 1'b0; if3.pop = 1'b0; if3.din = '0;
`ifdef TILE_FIFO_TRANSPOSE_EN
        if5.din_transpose = 1'b0;
        if3.din_transpose = 1'b0;
`endif
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state, DEPTH=3
        check("d3.count",    32'(if3.count),        32'd0);
        check("d3.empty",    32'(if3.empty),        32'd1);
        check("d3.full",     32'(if3.full),         32'd0);
        check("d3.pop_rdy",  32'(if3.pop_rdy),      32'd0);
        check("d3.push_rdy", 32'(if3.push_rdy),     32'd1);
        check("d3.dout",     32'(if3.dout),         32'd0);
        check("d3.aempty",   32'(if3.almost_empty), 32'd1);
        check("d3.afull",    32'(if3.almost_full),  32'd0);
        if3.pop = 1'b1;
        step();
        if3.pop = 1'b0;
        check("d3.pop_empty.count", 32'(if3.count), 32'd0);
        check("d3.pop_empty.empty", 32'(if3.empty), 32'd1);

        // Reset state, DEPTH=5
        flags5("rst5", 0);
        check("rst5.dout", 32'(if5.dout), 32'd0);

        // Fill T0..T4; head stays T0
        if5.push = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if5.din = fill(8'(8'h10 + k));
            step();
            flags5("fill", k + 1);
            check("fill.dout", 32'(if5.dout), 32'(fill(8'h10)));
        end

        // Push refused at full even with pop; T0 consumed
        if5.din = fill(8'h15);
        if5.pop = 1'b1;
        check("fullpop.dout", 32'(if5.dout), 32'(fill(8'h10)));
        step();
        if5.push = 1'b0;
        flags5("fullpop", 4);
        for (int k = 1; k < 5; k++) begin
            check("drain.dout", 32'(if5.dout), 32'(fill(8'(8'h10 + k))));
            step();
            flags5("drain", 4 - k);
        end
        if5.pop = 1'b0;
        check("drain.dout0", 32'(if5.dout), 32'd0);

        // Simultaneous push/pop at count 2 across pointer wraps
        if5.push = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if5.din = fill(8'(8'h40 + k));
            step();
        end
        flags5("pre_sim", 2);
        if5.pop = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if5.din = fill(8'(8'h42 + i));
            check("sim.dout", 32'(if5.dout), 32'(fill(8'(8'h40 + i))));
            step();
            check("sim.count", 32'(if5.count), 32'd2);
        end
        if5.push = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("sim_tail.dout", 32'(if5.dout), 32'(fill(8'(8'h4C + i))));
            step();
        end
        if5.pop = 1'b0;
        flags5("post_sim", 0);

        // Flush overrides push and pop
        if5.push = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if5.din = fill(8'(8'h60 + k));
            step();
        end
        flags5("pre_flush", 3);
        if5.flush = 1'b1;
        if5.pop   = 1'b1;
        if5.din   = fill(8'h77);
        step();
        if5.flush = 1'b0;
        if5.push  = 1'b0;
        if5.pop   = 1'b0;
        flags5("flush", 0);
        check("flush.dout", 32'(if5.dout), 32'd0);
        if5.push = 1'b1;
        if5.din  = fill(8'hAB);
        step();
        if5.push = 1'b0;
        check("flush_ab.dout", 32'(if5.dout), 32'(fill(8'hAB)));
        flags5("flush_ab", 1);

        // Same sequence with reset in place of flush
        if5.push = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if5.din = fill(8'(8'h81 + k));
            step();
        end
        flags5("pre_rst", 3);
        rst_n    = 1'b0;
        if5.pop  = 1'b1;
        if5.din  = fill(8'h99);
        step();
        rst_n    = 1'b1;
        if5.push = 1'b0;
        if5.pop  = 1'b0;
        flags5("rst_mid", 0);
        check("rst_mid.dout", 32'(if5.dout), 32'd0);
        if5.push = 1'b1;
        if5.din  = fill(8'hAB);
        step();
        if5.push = 1'b0;
        check("rst_ab.dout", 32'(if5.dout), 32'(fill(8'hAB)));
        flags5("rst_ab", 1);
        if5.pop = 1'b1;
        step();
        if5.pop = 1'b0;
        flags5("rst_ab_pop", 0);

        // Tile {{1,2},{3,4}} written transposed then unchanged
        if5.din  = {8'd1, 8'd2, 8'd3, 8'd4};
        if5.push = 1'b1;
`ifdef TILE_FIFO_TRANSPOSE_EN
        if5.din_transpose = 1'b1;
        step();
        if5.din_transpose = 1'b0;
        step();
        if5.push = 1'b0;
        check("tr.dout_t", 32'(if5.dout), 32'h01030204);
`else
        step();
        step();
        if5.push = 1'b0;
        check("tr.dout_t", 32'(if5.dout), 32'h01020304);
`endif
        if5.pop = 1'b1;
        step();
        check("tr.dout_n", 32'(if5.dout), 32'h01020304);
        step();
        if5.pop = 1'b0;
        flags5("tr_end", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
